// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, FSM state encoding and radix-4 Booth recode selector.
// Used by all booth_mul_ctrl files; BOOTH_UNSIGNED_EN is handled in the interface and top.
package booth_pkg;
  localparam int W = 64;
  localparam int ACC_W = W + 2;
  localparam int ITER = W / 2;
  typedef enum logic [1:0] {S_IDLE, S_NEG, S_ITER, S_DONE} state_t;
  typedef enum logic [2:0] {PP_ZERO, PP_PX, PP_P2X, PP_NX, PP_N2X} pp_sel_t;
  function automatic pp_sel_t recode(input logic [2:0] w);
    return (w == 3'b000 || w == 3'b111) ? PP_ZERO :
           (w == 3'b011) ? PP_P2X :
           (w == 3'b100) ? PP_N2X :
           w[2] ? PP_NX : PP_PX;
  endfunction
endpackage

// File: rtl/booth_mul_ctrl_if.sv
// booth_mul_ctrl_if: operand/result valid-ready bundle; in_signed exists only with BOOTH_UNSIGNED_EN.
interface booth_mul_ctrl_if;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_x, in_y;
  logic [127:0] out_p;
`ifdef BOOTH_UNSIGNED_EN
  logic in_signed;
`endif
  modport master (
`ifdef BOOTH_UNSIGNED_EN
    output in_signed,
`endif
    output in_valid, in_x, in_y, out_ready,
    input in_ready, out_valid, out_p, busy
  );
  modport slave (
`ifdef BOOTH_UNSIGNED_EN
    input in_signed,
`endif
    input in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/adder_66.sv
// adder_66: the single shared 66-bit adder; carry-out is never needed.
module adder_66 (
  input  logic [65:0] a,
  input  logic [65:0] b,
  output logic [65:0] s
);
  assign s = a + b;
endmodule

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: maps a 3-bit Booth window to the 66-bit partial product from X and NX.
module booth_pp_sel
  import booth_pkg::*;
(
  input  logic [2:0]       win,
  input  logic [ACC_W-1:0] x,
  input  logic [ACC_W-1:0] nx,
  output logic [ACC_W-1:0] pp
);
  pp_sel_t sel;
  assign sel = recode(win);
  always_comb
    pp = (sel == PP_PX)  ? x :
         (sel == PP_P2X) ? {x[ACC_W-2:0], 1'b0} :
         (sel == PP_NX)  ? nx :
         (sel == PP_N2X) ? {nx[ACC_W-2:0], 1'b0} : '0;
endmodule

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: iterative radix-4 Booth 64x64 -> 128 multiplier sharing one adder_66.
// BOOTH_UNSIGNED_EN adds a per-op in_signed select (unsigned ops take one extra iteration).
module booth_mul_ctrl
  import booth_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  booth_mul_ctrl_if.slave bus
);
  state_t state, nxt;
  logic [ACC_W-1:0] x, nx, acc, y, a, b, sum, pp;
  logic y_ext, sgn, in_sgn;
  logic [5:0] cnt, last;
`ifdef BOOTH_UNSIGNED_EN
  assign in_sgn = bus.in_signed;
`else
  assign in_sgn = 1'b1;
`endif
  // Y is kept 66 bits wide so an unsigned op can run a 33rd, zero-extended pair.
  assign last = sgn ? 6'(ITER - 1) : 6'(ITER);
  booth_pp_sel u_pp (.win({y[1:0], y_ext}), .x(x), .nx(nx), .pp(pp));
  adder_66 u_add (.a(a), .b(b), .s(sum));
  always_comb begin
    a = (state == S_NEG) ? ~x : acc;
    b = (state == S_NEG) ? ACC_W'(1) : pp;
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = bus.in_valid ? S_NEG : S_IDLE;
      S_NEG:  nxt = S_ITER;
      S_ITER: nxt = (cnt == last) ? S_DONE : S_ITER;
      S_DONE: nxt = bus.out_ready ? S_IDLE : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x <= '0;
      nx <= '0;
      acc <= '0;
      y <= '0;
      y_ext <= 1'b0;
      cnt <= '0;
      sgn <= 1'b1;
    end else begin
      state <= nxt;
      if (state == S_IDLE && bus.in_valid) begin
        x <= {{2{bus.in_x[W-1] & in_sgn}}, bus.in_x};
        y <= {{2{bus.in_y[W-1] & in_sgn}}, bus.in_y};
        acc <= '0;
        y_ext <= 1'b0;
        cnt <= '0;
        sgn <= in_sgn;
      end
      if (state == S_NEG) nx <= sum;
      if (state == S_ITER) begin
        {acc, y, y_ext} <= {{2{sum[ACC_W-1]}}, sum, y[ACC_W-1:1]};
        cnt <= cnt + 6'd1;
      end
    end
  end
  assign bus.in_ready = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy = (state != S_IDLE);
  assign bus.out_p = (state != S_DONE) ? '0 : sgn ? {acc[W-1:0], y[ACC_W-1:2]} : {acc[W-3:0], y};
endmodule
